// File: rtl/program_feeder.sv
// program_feeder: walks a processor through a short program held in local memory,
// inserting the immediate word after MVI and policing the Done handshake.
//
// state  | meaning
// IDLE   | out of reset, waiting for Start
// ISSUE  | instruction word on Din with Run high
// IMM    | immediate word on Din, Done must arrive this cycle
// WAIT   | waiting for Done, timeout counter running
// HALTED | program completed
// ERR    | protocol error, waiting for Start
module program_feeder #(
    parameter logic [2:0] OPC_MVI = 3'b001,
    parameter int         DEPTH   = 16,
    parameter int         TIMEOUT = 7
) (
    input  logic       clock,
    input  logic       aReset,
    input  logic       Start,
    input  logic [4:0] ProgLen,
    input  logic       LdEn,
    input  logic [3:0] LdAddr,
    input  logic [8:0] LdData,
    input  logic       Done,
    output logic       Run,
    output logic [8:0] Din,
    output logic       Busy,
    output logic       Finished,
    output logic       Error,
    output logic [3:0] PC,
    output logic [7:0] InstrCount
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_IMM    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [7:0] TMO_LD = 8'(TIMEOUT);

    logic [2:0] state;
    logic [4:0] pc;
    logic [4:0] len;
    logic [7:0] tmr;
    logic [7:0] icount;
    logic       fin;
    logic [8:0] mem [DEPTH];

    logic [8:0] word;
    logic [4:0] pc_inc;
    logic       idle_like;
    logic       start_ok;
    logic       is_mvi;
    logic       last_word;

    assign word      = mem[pc[3:0]];
    assign pc_inc    = pc + 5'd1;
    assign idle_like = (state == S_IDLE) || (state == S_HALTED) || (state == S_ERR);
    assign start_ok  = (ProgLen != 5'd0) && (ProgLen <= 5'd16);
    assign is_mvi    = (word[8:6] == OPC_MVI);
    assign last_word = (pc == len - 5'd1);

    // Memory is deliberately outside the reset domain so a program survives aReset.
    always_ff @(posedge clock) begin
        if (LdEn && idle_like) begin
            mem[LdAddr] <= LdData;
        end
    end

    always_ff @(posedge clock or posedge aReset) begin
        if (aReset) begin
            state  <= S_IDLE;
            pc     <= 5'd0;
            len    <= 5'd0;
            tmr    <= 8'd0;
            icount <= 8'd0;
            fin    <= 1'b0;
        end else begin
            fin <= 1'b0;
            case (state)
                S_IDLE, S_HALTED, S_ERR: begin
                    if (Start) begin
                        if (start_ok) begin
                            state  <= S_ISSUE;
                            pc     <= 5'd0;
                            icount <= 8'd0;
                            len    <= ProgLen;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                end
                S_ISSUE: begin
                    // An MVI with no word left for its immediate is refused outright.
                    if (is_mvi && last_word) begin
                        state <= S_ERR;
                    end else begin
                        pc    <= pc_inc;
                        tmr   <= TMO_LD;
                        state <= is_mvi ? S_IMM : S_WAIT;
                    end
                end
                S_IMM: begin
                    if (Done) begin
                        pc     <= pc_inc;
                        icount <= icount + 8'd1;
                        if (pc_inc == len) begin
                            state <= S_HALTED;
                            fin   <= 1'b1;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end else begin
                        state <= S_ERR;
                    end
                end
                S_WAIT: begin
                    if (Done) begin
                        icount <= icount + 8'd1;
                        if (pc == len) begin
                            state <= S_HALTED;
                            fin   <= 1'b1;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end else if (tmr == 8'd1) begin
                        state <= S_ERR;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Run        = (state == S_ISSUE) && !(is_mvi && last_word);
    assign Din        = ((state == S_ISSUE) || (state == S_IMM)) ? word : 9'd0;
    assign Busy       = !idle_like;
    assign Finished   = fin;
    assign Error      = (state == S_ERR);
    assign PC         = pc[3:0];
    assign InstrCount = icount;

endmodule

// File: doc/program_feeder.md
PROGRAM_FEEDER -- requirements
Module: program_feeder

Interface
REQ-001 SHALL have parameters: OPC_MVI, default 3'b001, opcode needing an immediate word; DEPTH, default 16, program memory words; TIMEOUT, default 7, max cycles waiting for Done.
REQ-002 SHALL have ports: clock  input  1  single clock, all state on rising edge.
REQ-003 aReset  input  1  asynchronous active-high reset.
REQ-004 Start  input  1  begin executing program from word 0.
REQ-005 ProgLen  input  5  number of program words to issue, 1..16, sampled on Start.
REQ-006 LdEn  input  1  program memory write enable.
REQ-007 LdAddr  input  4  program memory write address.
REQ-008 LdData  input  9  program memory write data.
REQ-009 Done  input  1  processor instruction-complete strobe.
REQ-010 Run  output  1  processor run request.
REQ-011 Din  output  9  word driven onto processor data input.
REQ-012 Busy  output  1  high when not in IDLE, ERR or HALTED.
REQ-013 Finished  output  1  one-cycle pulse on program completion.
REQ-014 Error  output  1  protocol error flag.
REQ-015 PC  output  4  address of current or next program word.
REQ-016 InstrCount  output  8  instructions completed since last Start.

Function
REQ-017 Memory SHALL be DEPTH x 9 bits, written synchronously when LdEn=1 in IDLE, HALTED or ERR; writes SHALL be ignored in other states.
REQ-018 Word format SHALL be opcode [8:6], X [5:3], Y [2:0]; opcode==OPC_MVI SHALL mean the next word is immediate data.
REQ-019 FSM states SHALL be IDLE, ISSUE, IMM, WAIT, HALTED, ERR.
REQ-020 IDLE/HALTED: Run=0, Din=0; Start=1 with ProgLen in 1..16 SHALL go to ISSUE with PC=0, InstrCount=0, Error=0.
REQ-021 Start with ProgLen=0 or >16 SHALL go to ERR with Error=1.
REQ-022 ISSUE (one cycle): Run=1, Din=mem[PC]; Done ignored; PC increments.
REQ-023 From ISSUE, an MVI opcode SHALL go to IMM; all other opcodes SHALL go to WAIT.
REQ-024 An MVI opcode at the last word (PC==ProgLen-1) SHALL go to ERR, leave PC unchanged, and drive Run=0 in place of Run=1.
REQ-025 IMM (one cycle): Run=0, Din=mem[PC]; Done=1 SHALL complete the instruction and increment PC; Done=0 SHALL go to ERR.
REQ-026 WAIT: Run=0, Din=0; a cycle counter SHALL run from 1; Done=1 SHALL complete the instruction; reaching TIMEOUT cycles with no Done SHALL go to ERR.
REQ-027 On completion, InstrCount SHALL increment, wrapping modulo 256.
REQ-028 After completion, PC<ProgLen SHALL go to ISSUE next cycle (no gap); PC==ProgLen SHALL go to HALTED and pulse Finished for that one cycle.
REQ-029 Start in any state other than IDLE, HALTED or ERR SHALL be ignored.
REQ-030 ERR: Run=0, Din=0, Error=1 held; Start SHALL restart per REQ-020.
REQ-031 LdEn and Start in the same IDLE cycle: the write SHALL commit, and ISSUE SHALL read the updated word.

Reset
REQ-032 aReset=1 SHALL immediately force IDLE, with Run=0, Din=0, Busy=0, Finished=0, Error=0, PC=0, InstrCount=0, regardless of state.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 Reset mid-instruction SHALL drop Run in the same cycle, with no further Din words issued.

Verification
REQ-035 Load mem[0]=9'b000_001_010 (mv), ProgLen=1, Start; Done=1 two cycles after ISSUE -> Run high for exactly 1 cycle, Din=0x00A, Finished pulse, InstrCount=1, HALTED.
REQ-036 Load mem[0]=9'b001_011_000, mem[1]=0x155, ProgLen=2, Start; Done=1 in IMM -> Din=0x058 then 0x155 on consecutive cycles, Finished, InstrCount=1.
REQ-037 Run add, then sub (ProgLen=2) with Done after 3 WAIT cycles each -> second ISSUE the cycle after the first Done, InstrCount=2, PC=2.
REQ-038 Hold Done=0 after ISSUE -> Error=1 after exactly 7 WAIT cycles, Busy=0; Start then restarts at PC=0 with Error=0.
REQ-039 ProgLen=1 with mem[0] MVI -> ERR, Error=1, Run never asserted; ProgLen=0 -> ERR.
REQ-040 Assert aReset during WAIT -> Run=0 and PC=0 asynchronously; memory contents unchanged on re-Start.
